mouse_bus_reader: RTL and testbench

- Hardware bus master that services the PS/2 mouse peripheral's interrupt without the processor.
- On MOUSE_INTERRUPT_RAISE it acknowledges, requests the shared data bus, and reads status/X/Y/scroll registers at BASE_ADDR..BASE_ADDR+3.
- Commits the four bytes atomically to output registers for the VGA/LED logic.
- Sits between the bus arbiter and the mouse peripheral, as a second bus master beside the processor.

---
 rtl/mouse_bus_reader.sv | 153 +++++++++++++++
 tb/tb_mouse_bus_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_bus_reader.sv
// Bus master that answers the PS/2 mouse interrupt and reads the four mouse
// registers over the shared bus. It then publishes them as one atomic frame.
module mouse_bus_reader #(
  parameter logic [7:0]  BASE_ADDR = 8'hA0,
  parameter logic [7:0]  IDLE_ADDR = 8'hFF,
  parameter int unsigned READ_WAIT = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       MOUSE_INTERRUPT_RAISE,
  output logic       MOUSE_INTERRUPT_ACK,
  output logic       BUS_REQ,
  input  logic       BUS_GNT,
  output logic [7:0] BUS_ADDR,
  output logic       BUS_WE,
  inout  wire  [7:0] BUS_DATA,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_X,
  output logic [7:0] MOUSE_Y,
  output logic [7:0] MOUSE_Z,
  output logic       FRAME_VALID,
  output logic [7:0] FRAME_COUNT
);

  localparam int unsigned CNT_W = (READ_WAIT > 2) ? $clog2(READ_WAIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_WAIT_GNT,
    S_ADDR,
    S_COMMIT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture;

  logic       ack_q, ack_d;
  logic       req_q, req_d;
  logic [7:0] addr_q, addr_d;
  logic       valid_q, valid_d;
  logic [7:0] count_q, count_d;

  // This block only ever reads the shared data bus.
  assign BUS_DATA = 8'bzzzz_zzzz;
  assign BUS_WE   = 1'b0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (MOUSE_INTERRUPT_RAISE) state_d = S_ACK;
      end
      S_ACK: begin
        idx_d   = '0;
        cnt_d   = '0;
        state_d = S_WAIT_GNT;
      end
      S_WAIT_GNT: begin
        if (BUS_GNT) state_d = S_ADDR;
      end
      S_ADDR: begin
        // A lost grant restarts the current register's address phase in full.
        if (!BUS_GNT) begin
          cnt_d   = '0;
          state_d = S_WAIT_GNT;
        end else if (cnt_q == LAST_CNT) begin
          capture = 1'b1;
          cnt_d   = '0;
          if (idx_q == 2'd3) state_d = S_COMMIT;
          else               idx_d   = 2'(idx_q + 2'd1);
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus-side outputs are registered from the next state so they line up with it.
  always_comb begin
    ack_d   = (state_d == S_ACK);
    req_d   = (state_d == S_ACK) || (state_d == S_WAIT_GNT) || (state_d == S_ADDR);
    addr_d  = (state_d == S_ADDR) ? 8'(BASE_ADDR + {6'd0, idx_d}) : IDLE_ADDR;
    valid_d = (state_d == S_COMMIT);
    count_d = (state_q == S_COMMIT) ? 8'(count_q + 8'd1) : count_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= IDLE_ADDR;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      ack_q   <= ack_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    logic [7:0] shadow_q;
    logic [7:0] frame_q;

    always_ff @(posedge CLK) begin
      if (RESET) begin
        shadow_q <= '0;
        frame_q  <= '0;
      end else begin
        if (capture && (idx_q == 2'(gi))) shadow_q <= BUS_DATA;
        if (state_q == S_COMMIT)           frame_q  <= shadow_q;
      end
    end
  end

  assign MOUSE_INTERRUPT_ACK = ack_q;
  assign BUS_REQ             = req_q;
  assign BUS_ADDR            = addr_q;
  assign FRAME_VALID         = valid_q;
  assign FRAME_COUNT         = count_q;
  assign MOUSE_STATUS        = g_byte[0].frame_q;
  assign MOUSE_X             = g_byte[1].frame_q;
  assign MOUSE_Y             = g_byte[2].frame_q;
  assign MOUSE_Z             = g_byte[3].frame_q;

endmodule

// File: tb/tb_mouse_bus_reader.sv
// Bench for mouse_bus_reader: directed timing traces plus randomized frames
// against a register-file peripheral and a frame-level expectation model.
module tb_mouse_bus_reader;

  localparam logic [7:0] BASE = 8'hA0;
  localparam logic [7:0] IDLE = 8'hFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, raise, gnt;
  logic       ack, req, we, valid;
  logic [7:0] addr, st, mx, my, mz, fcnt;
  logic [7:0] per_data = 8'h5A;
  wire  [7:0] bus_data;
  logic [7:0] regs [4];
  logic [7:0] snap [4];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_count = 0;

  assign bus_data = per_data;

  mouse_bus_reader dut (
    .CLK                   (clk),
    .RESET                 (reset),
    .MOUSE_INTERRUPT_RAISE (raise),
    .MOUSE_INTERRUPT_ACK   (ack),
    .BUS_REQ               (req),
    .BUS_GNT               (gnt),
    .BUS_ADDR              (addr),
    .BUS_WE                (we),
    .BUS_DATA              (bus_data),
    .MOUSE_STATUS          (st),
    .MOUSE_X               (mx),
    .MOUSE_Y               (my),
    .MOUSE_Z               (mz),
    .FRAME_VALID           (valid),
    .FRAME_COUNT           (fcnt)
  );

  // Peripheral: registered read, one cycle of latency; junk when not addressed.
  always @(posedge clk) begin
    if (addr >= BASE && addr <= 8'(BASE + 8'd3)) per_data <= regs[addr[1:0]];
    else                                          per_data <= 8'h5A;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Continuous checks: write enable, bus never disturbed, atomic commit, single-cycle valid.
  logic        mon_en = 1'b0;
  logic        rst_at_edge = 1'b1;
  logic        prev_valid = 1'b0;
  logic [39:0] prev_out = '0;

  always @(posedge clk) rst_at_edge <= reset;

  always @(negedge clk) begin
    if (mon_en) begin
      check_val("bus_we_low", we, 1'b0);
      check_val("bus_data_undisturbed", bus_data, per_data);
      if (!rst_at_edge)
        check_val("atomic_commit", ({st, mx, my, mz, fcnt} != prev_out) && !prev_valid, 1'b0);
      check_val("valid_one_cycle", valid && prev_valid, 1'b0);
    end
    prev_out   = {st, mx, my, mz, fcnt};
    prev_valid = valid;
  end

  // The peripheral holds its level interrupt until it sees the acknowledge.
  task automatic tick();
    @(negedge clk);
    if (ack) raise = 1'b0;
  endtask

  task automatic wait_addr(input logic [7:0] a, input string tag);
    int n = 0;
    while (addr !== a && n < 60) begin
      tick();
      n++;
    end
    check_val(tag, addr, a);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check_val(tag, valid, 1'b1);
  endtask

  task automatic load_regs();
    for (int i = 0; i < 4; i++) begin
      regs[i] = 8'($urandom);
      snap[i] = regs[i];
    end
  endtask

  task automatic check_frame(input string tag);
    check_val({tag, "_status"}, st, snap[0]);
    check_val({tag, "_x"}, mx, snap[1]);
    check_val({tag, "_y"}, my, snap[2]);
    check_val({tag, "_z"}, mz, snap[3]);
    check_val({tag, "_count"}, fcnt, exp_count);
    $display("[TB] %s frame: status=%02h x=%02h y=%02h z=%02h count=%0d", tag, st, mx, my, mz, fcnt);
  endtask

  task automatic random_frame(input bit rand_gnt);
    int n = 0;
    load_regs();
    raise = 1'b1;
    while (valid !== 1'b1 && n < 400) begin
      gnt = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    check_val("rand_valid_seen", valid, 1'b1);
    tick();
    exp_count = (exp_count + 1) % 256;
    check_frame("rand");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_addr;
    int gap;
    reset = 1'b1;
    raise = 1'b0;
    gnt   = 1'b0;
    for (int i = 0; i < 4; i++) regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Reset state.
    check_val("rst_addr", addr, IDLE);
    check_val("rst_req", req, 1'b0);
    check_val("rst_ack", ack, 1'b0);
    check_val("rst_valid", valid, 1'b0);
    check_val("rst_data", {st, mx, my, mz}, 32'h0);
    check_val("rst_count", fcnt, 8'h00);
    $display("[TB] reset state checked");

    // Uncontended frame, cycle by cycle relative to the edge that samples RAISE.
    regs[0] = 8'h09; regs[1] = 8'h50; regs[2] = 8'h3C; regs[3] = 8'h02;
    for (int i = 0; i < 4; i++) snap[i] = regs[i];
    gnt   = 1'b1;
    raise = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_addr = (k >= 3 && k <= 10) ? 8'(BASE + 8'((k - 3) / 2)) : IDLE;
      check_val($sformatf("trace_t%0d_addr", k), addr, exp_addr);
      check_val($sformatf("trace_t%0d_ack", k), ack, k == 1);
      check_val($sformatf("trace_t%0d_req", k), req, k <= 10);
      check_val($sformatf("trace_t%0d_valid", k), valid, k == 11);
      if (k <= 11) check_val($sformatf("trace_t%0d_nodata", k), st, 8'h00);
    end
    exp_count = 1;
    check_frame("trace");

    // Grant lost for 3 cycles starting on the first A2 cycle.
    load_regs();
    gnt   = 1'b1;
    raise = 1'b1;
    wait_addr(8'(BASE + 8'd2), "stall_a2_seen");
    gnt = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_val($sformatf("stall_c%0d_addr", k), addr, IDLE);
      check_val($sformatf("stall_c%0d_req", k), req, 1'b1);
      check_val($sformatf("stall_c%0d_valid", k), valid, 1'b0);
    end
    gnt = 1'b1;
    for (int k = 4; k <= 8; k++) begin
      tick();
      exp_addr = (k <= 5) ? 8'(BASE + 8'd2) : (k <= 7) ? 8'(BASE + 8'd3) : IDLE;
      check_val($sformatf("stall_c%0d_addr", k), addr, exp_addr);
      check_val($sformatf("stall_c%0d_valid", k), valid, k == 8);
    end
    tick();
    exp_count++;
    check_frame("stall");

    // RAISE re-asserted mid-frame: two commits back to back.
    load_regs();
    raise = 1'b1;
    wait_addr(8'(BASE + 8'd1), "mid_a1_seen");
    raise = 1'b1;
    wait_valid("mid_first_valid");
    tick();
    exp_count++;
    check_frame("mid_first");
    gap = 0;
    while (ack !== 1'b1 && gap < 4) begin
      tick();
      gap++;
    end
    check_val("mid_second_ack_prompt", (ack === 1'b1) && (gap <= 2), 1'b1);
    wait_valid("mid_second_valid");
    tick();
    exp_count++;
    check_frame("mid_second");

    // Reset during the A1 phase aborts the frame.
    load_regs();
    raise = 1'b1;
    wait_addr(8'(BASE + 8'd1), "rstmid_a1_seen");
    reset = 1'b1;
    tick();
    check_val("rstmid_req", req, 1'b0);
    check_val("rstmid_addr", addr, IDLE);
    check_val("rstmid_valid", valid, 1'b0);
    check_val("rstmid_data", {st, mx, my, mz}, 32'h0);
    check_val("rstmid_count", fcnt, 8'h00);
    reset = 1'b0;
    exp_count = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check_val("rstmid_no_valid", valid, 1'b0);
    end
    random_frame(1'b0);

    // Random grant pattern; 255 further frames wrap the counter to zero.
    for (int f = 0; f < 255; f++) random_frame(1'b1);
    check_val("count_wrap", fcnt, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
